switch_debounce: RTL
====================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CNT, 50000, consecutive stable cycles required before an output bit changes (legal range 1..2^CNT_W-1).
REQ-002 SHALL have parameter: CNT_W, 16, width of each per-bit stability counter.
REQ-003 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: sw_in  input  5  raw board switches {lights, brake, hazard, right, left}, asynchronous to clock.
REQ-006 SHALL have port: sw_out  output  5  debounced switches, same bit order, feeding the tail-light state machine and dimmer.
REQ-007 SHALL have port: changed  output  1  one-cycle pulse when any debounced bit updates.

Function
REQ-008 SHALL pass each sw_in bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-009 SHALL keep, per bit i, a debounced register db[i] and a counter cnt[i] of CNT_W bits.
REQ-010 SHALL clear cnt[i] on any edge where s2[i] equals db[i].
REQ-011 SHALL increment cnt[i] on each edge where s2[i] differs from db[i] and cnt[i] < DEBOUNCE_CNT-1.
REQ-012 SHALL, on an edge where s2[i] differs from db[i] and cnt[i] == DEBOUNCE_CNT-1, load db[i] <= s2[i] and clear cnt[i].
REQ-013 SHALL give latency exactly DEBOUNCE_CNT+2 clocks: input stable from edge k -> db updates at edge k+2+DEBOUNCE_CNT.
REQ-014 SHALL discard any excursion shorter than DEBOUNCE_CNT cycles at s2 (counter cleared, db unchanged).
REQ-015 SHALL never wrap cnt[i]; its maximum value is DEBOUNCE_CNT-1.
REQ-016 SHALL, with DEBOUNCE_CNT == 1, update db[i] on the first mismatching edge (latency 3).
REQ-017 SHALL debounce all five bits independently; bits meeting REQ-012 on the same edge update together.
REQ-018 SHALL drive changed = 1 for exactly the one cycle following an edge on which at least one db bit changed value; otherwise 0.
REQ-019 SHALL derive sw_out only from db registers (no path from sw_in, s1 or s2).

Reset
REQ-020 SHALL, while reset is low, asynchronously force s1, s2, db, cnt and changed to 0; sw_out therefore reads 5'b00000.
REQ-021 SHALL abandon any in-progress count on reset; after release, a high input requires the full DEBOUNCE_CNT+2 clocks.
REQ-022 SHALL resume normal operation on the first rising clock edge after reset goes high.

Configuration
REQ-023 SHALL, when macro SWITCH_DEBOUNCE_MERGE_EN is defined, drive sw_out[0] = db[0] & ~db[1], sw_out[1] = db[1] & ~db[0], sw_out[2] = db[2] | (db[0] & db[1]), and sw_out[4:3] = db[4:3] (left+right together presented as hazard).
REQ-024 SHALL, when SWITCH_DEBOUNCE_MERGE_EN is undefined, drive sw_out = db directly.
REQ-025 SHALL keep changed based on db transitions in both builds.

Verification (DEBOUNCE_CNT = 4)
REQ-026 SHALL cover: reset low, sw_in = 5'b11111 -> sw_out = 0 and changed = 0 throughout reset.
REQ-027 SHALL cover: sw_in[0] 0->1 held from edge k -> sw_out[0] = 1 from edge k+6; changed high for the single cycle after edge k+6.
REQ-028 SHALL cover: sw_in[3] high for 3 cycles then low -> sw_out stays 5'b00000; changed never asserts.
REQ-029 SHALL cover: sw_in = 5'b00011 held -> sw_out = 5'b00011 without the macro; 5'b00100 with SWITCH_DEBOUNCE_MERGE_EN.
REQ-030 SHALL cover: sw_in[1] high; reset pulsed low at edge k+4 -> sw_out[1] = 0 immediately; after release sw_out[1] = 1 exactly 6 edges later.
REQ-031 SHALL cover: sw_in[2] and sw_in[4] rise on the same edge -> both sw_out bits rise on the same edge; one single-cycle changed pulse.

Source files
------------

// File: rtl/switch_debounce.sv
// Five-bit switch debouncer: two-flop synchronizer, per-bit saturating stability counter, registered change pulse.
// Optional build macro SWITCH_DEBOUNCE_MERGE_EN presents left+right together as hazard on sw_out.
module switch_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 50000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] sw_in,
   output logic [4:0] sw_out,
   output logic       changed
);

   localparam int unsigned      NB      = 5;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

   logic [NB-1:0]    s1, s2;
   logic [NB-1:0]    db, db_nxt;
   logic [CNT_W-1:0] cnt     [NB];
   logic [CNT_W-1:0] cnt_nxt [NB];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   // A counter only runs while s2 disagrees with db, so it saturates at CNT_MAX and never wraps.
   always_comb begin
      db_nxt = db;
      for (int unsigned i = 0; i < NB; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != db[i]) begin
            if (cnt[i] == CNT_MAX) begin
               db_nxt[i] = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         db      <= '0;
         changed <= 1'b0;
         for (int unsigned i = 0; i < NB; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         db      <= db_nxt;
         changed <= |(db_nxt ^ db);
         for (int unsigned i = 0; i < NB; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

`ifdef SWITCH_DEBOUNCE_MERGE_EN
   always_comb begin
      sw_out[0]   = db[0] & ~db[1];
      sw_out[1]   = db[1] & ~db[0];
      sw_out[2]   = db[2] | (db[0] & db[1]);
      sw_out[4:3] = db[4:3];
   end
`else
   assign sw_out = db;
`endif

endmodule
